// File: rtl/dma_rd_arb_pkg.sv
// dma_rd_arb_pkg: shared types for the DMA read-channel arbiter.
// Holds the FSM state encoding, default widths and an index-width helper.
package dma_rd_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } arb_state_e;

  localparam int N_REQ_DEF   = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 64;
  localparam int SIZE_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 4096;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i.
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot, idx_o index, any_o.
module rr_arbiter
  import dma_rd_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] c;

  // Walk from the farthest offset back to ptr_i so the
  // nearest requester at or after the pointer wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = {1'b0, ptr_i} + (IW+1)'(k);
      if (c >= (IW+1)'(N)) c = c - (IW+1)'(N);
      if (req_i[c[IW-1:0]]) begin
        idx_o = c[IW-1:0];
        any_o = 1'b1;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares one DMA read channel between N_REQ requesters,
// round-robin, one whole burst per grant. Optional watchdog: DMA_RD_ARB_TIMEOUT_EN.
// Ports: req_* requester side (areq/addr/size/rready in, busy/rvalid/rdata out),
// grant_id current grantee, dma_* DMA side, timeout_err watchdog abort pulse.
module dma_rd_arbiter
  import dma_rd_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SIZE_W      = SIZE_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                     clk_50M,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         req_areq,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*SIZE_W-1:0]  req_size,
  input  logic [N_REQ-1:0]         req_rready,
  output logic [N_REQ-1:0]         req_busy,
  output logic [N_REQ-1:0]         req_rvalid,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [ADDR_W-1:0]        dma_raddr,
  output logic [SIZE_W-1:0]        dma_rsize,
  output logic                     dma_rareq,
  input  logic                     dma_rbusy,
  input  logic [DATA_W-1:0]        dma_rdata,
  input  logic                     dma_rvalid,
  output logic                     dma_rready,
  output logic                     timeout_err
);

  localparam int GW = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  busy_q, busy_d;
  logic              rareq_q, rareq_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [GW-1:0]     ptr_q, ptr_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [GW-1:0]     arb_idx;
  logic              arb_any;
  logic              beat;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr (
    .req_i (req_areq),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef DMA_RD_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          terr_q, terr_d;
`endif

  assign beat = (state_q == S_XFER) & dma_rvalid & dma_rready;

  always_ff @(posedge clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= '0;
      rareq_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rareq_q <= rareq_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef DMA_RD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    rareq_d = rareq_q;
    addr_d  = addr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_areq) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_any) begin
          state_d = S_ISSUE;
          gid_d   = arb_idx;
          addr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          size_d  = req_size[int'(arb_idx)*SIZE_W +: SIZE_W];
          busy_d  = arb_gnt;
          cnt_d   = '0;
          // Hold off while the previous burst's busy tail drains.
          rareq_d = ~dma_rbusy;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (rareq_q && dma_rbusy) begin
          rareq_d = 1'b0;
          state_d = S_XFER;
        end else if (!rareq_q && !dma_rbusy) begin
          rareq_d = 1'b1;
        end
      end
      S_XFER: begin
        if (beat && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (!dma_rbusy && ((cnt_q == size_q) || (size_q == '0)))
          state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = '0;
        rareq_d = 1'b0;
        ptr_d   = (gid_q == GW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef DMA_RD_ARB_TIMEOUT_EN
    terr_d = 1'b0;
    wd_d   = '0;
    if ((state_q == S_ISSUE) || (state_q == S_XFER)) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
        state_d = S_DONE;
        rareq_d = 1'b0;
        terr_d  = 1'b1;
      end
    end
`endif
  end

  // Data path routing is combinational so beats reach the grantee same cycle.
  always_comb begin
    req_rvalid = '0;
    dma_rready = 1'b1;
    if (state_q == S_XFER) begin
      req_rvalid[gid_q] = dma_rvalid;
      dma_rready        = req_rready[gid_q];
    end
  end

  assign req_busy  = busy_q;
  assign req_rdata = dma_rdata;
  assign grant_id  = gid_q;
  assign dma_raddr = addr_q;
  assign dma_rsize = size_q;
  assign dma_rareq = rareq_q;

`ifdef DMA_RD_ARB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// tb_dma_rd_arbiter: directed bench for dma_rd_arbiter with a small DMA model.
// Watchdog scenario is built when DMA_RD_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_dma_rd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 16;
  localparam logic [63:0] DBASE = 64'hA5A5_0000_0000_0000;
`ifdef DMA_RD_ARB_TIMEOUT_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 150;
`endif

  logic          clk_50M = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  req_areq;
  logic [N*AW-1:0] req_addr;
  logic [N*SW-1:0] req_size;
  logic [N-1:0]  req_rready;
  logic [N-1:0]  req_busy;
  logic [N-1:0]  req_rvalid;
  logic [DW-1:0] req_rdata;
  logic [0:0]    grant_id;
  logic [AW-1:0] dma_raddr;
  logic [SW-1:0] dma_rsize;
  logic          dma_rareq;
  logic          dma_rbusy;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dma_rready;
  logic          timeout_err;

  logic dma_hang;
  int   m_nb, m_b;
  logic m_hs;

  int vectors = 0;
  int miscompares = 0;
  int beats [N];
  logic [63:0] last_rd [N];
  int overlap, order_code, terr_cnt;
  logic [N-1:0] busy_prev;

  always #5 clk_50M = ~clk_50M;

  dma_rd_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW),
    .SIZE_W(SW), .TIMEOUT_CYC(100)
  ) dut (
    .clk_50M(clk_50M), .i_rst_n(i_rst_n),
    .req_areq(req_areq), .req_addr(req_addr),
    .req_size(req_size), .req_rready(req_rready),
    .req_busy(req_busy), .req_rvalid(req_rvalid),
    .req_rdata(req_rdata), .grant_id(grant_id),
    .dma_raddr(dma_raddr), .dma_rsize(dma_rsize),
    .dma_rareq(dma_rareq), .dma_rbusy(dma_rbusy),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_rready(dma_rready), .timeout_err(timeout_err)
  );

  // DMA model: busy one cycle after rareq, then size beats honouring rready.
  initial begin
    dma_rbusy = 1'b0;
    dma_rvalid = 1'b0;
    dma_rdata = '0;
    forever begin
      @(posedge clk_50M); #1;
      if (dma_rareq && !dma_rbusy) begin
        m_nb = int'(dma_rsize);
        dma_rbusy = 1'b1;
        @(posedge clk_50M); #1;
        if (dma_hang) begin
          while (dma_hang) begin @(posedge clk_50M); #1; end
          m_nb = 0;
        end
        m_b = 0;
        while (m_b < m_nb) begin
          dma_rvalid = 1'b1;
          dma_rdata = DBASE + 64'(m_b);
          #7 m_hs = dma_rready;
          @(posedge clk_50M); #1;
          if (m_hs) m_b++;
        end
        dma_rvalid = 1'b0;
        dma_rbusy = 1'b0;
      end
    end
  end

  // One cycle: observe at negedge, requesters drop areq once granted.
  task automatic cyc();
    @(negedge clk_50M);
    for (int i = 0; i < N; i++) begin
      if (req_rvalid[i] && req_rready[i]) begin
        beats[i]++;
        last_rd[i] = req_rdata;
      end
      if (req_busy[i] && !busy_prev[i])
        order_code = order_code * 10 + i + 1;
      if (req_busy[i]) req_areq[i] = 1'b0;
    end
    if (&req_busy) overlap++;
    if (timeout_err) terr_cnt++;
    busy_prev = req_busy;
    @(posedge clk_50M); #2;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      beats[i] = 0;
      last_rd[i] = '0;
    end
    overlap = 0;
    order_code = 0;
    terr_cnt = 0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [SW-1:0] s);
    req_addr[i*AW +: AW] = a;
    req_size[i*SW +: SW] = s;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n;
    n = 0;
    while (!(req_busy == '0 && req_areq == '0 && !dma_rareq
             && !dma_rbusy) && n < lim) begin
      cyc();
      n++;
    end
    vectors++;
    if (n >= lim) begin
      miscompares++;
      $display("FAIL %s_idle: still busy after %0d cycles", nm, lim);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    req_areq = '0;
    req_addr = '0;
    req_size = '0;
    req_rready = '1;
    dma_hang = 1'b0;
    busy_prev = '0;
    clear_mon();
    repeat (3) cyc();
    vectors++; if (req_busy !== 2'b00) begin miscompares++;
      $display("FAIL rst_busy: got %b want 00", req_busy); end
    vectors++; if (dma_rareq !== 1'b0) begin miscompares++;
      $display("FAIL rst_rareq: got %b want 0", dma_rareq); end
    vectors++; if (dma_raddr !== 32'h0) begin miscompares++;
      $display("FAIL rst_raddr: got %h want 0", dma_raddr); end
    vectors++; if (dma_rsize !== 16'h0) begin miscompares++;
      $display("FAIL rst_rsize: got %h want 0", dma_rsize); end
    vectors++; if (grant_id !== 1'b0) begin miscompares++;
      $display("FAIL rst_gid: got %b want 0", grant_id); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++;
      $display("FAIL rst_terr: got %b want 0", timeout_err); end
    vectors++; if (req_rvalid !== 2'b00) begin miscompares++;
      $display("FAIL rst_rvalid: got %b want 00", req_rvalid); end
    i_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    clear_mon();
    set_req(0, 32'h1000_0000, 16'd64);
    req_areq = 2'b01;
    cyc();
    vectors++; if (dma_rareq !== 1'b0) begin miscompares++;
      $display("FAIL lat1_rareq: got %b want 0", dma_rareq); end
    cyc();
    vectors++; if (dma_rareq !== 1'b1) begin miscompares++;
      $display("FAIL lat2_rareq: got %b want 1", dma_rareq); end
    vectors++; if (dma_raddr !== 32'h1000_0000) begin miscompares++;
      $display("FAIL t1_raddr: got %h want 10000000", dma_raddr); end
    vectors++; if (dma_rsize !== 16'd64) begin miscompares++;
      $display("FAIL t1_rsize: got %0d want 64", dma_rsize); end
    vectors++; if (req_busy !== 2'b01) begin miscompares++;
      $display("FAIL t1_busy: got %b want 01", req_busy); end
    set_req(0, 32'hDEAD_0000, 16'd3);
    cyc();
    vectors++; if (dma_raddr !== 32'h1000_0000) begin miscompares++;
      $display("FAIL t1_latch_addr: got %h want 10000000", dma_raddr); end
    vectors++; if (dma_rsize !== 16'd64) begin miscompares++;
      $display("FAIL t1_latch_size: got %0d want 64", dma_rsize); end
    wait_idle(400, "t1");
    vectors++; if (beats[0] !== 64) begin miscompares++;
      $display("FAIL t1_beats0: got %0d want 64", beats[0]); end
    vectors++; if (beats[1] !== 0) begin miscompares++;
      $display("FAIL t1_beats1: got %0d want 0", beats[1]); end
    vectors++; if (last_rd[0] !== DBASE + 64'd63) begin miscompares++;
      $display("FAIL t1_rdata: got %h want %h", last_rd[0], DBASE + 64'd63); end
  endtask

  task automatic test_both();
    do_reset();
    clear_mon();
    set_req(0, 32'h2000_0000, 16'd8);
    set_req(1, 32'h3000_0000, 16'd8);
    req_areq = 2'b11;
    wait_idle(400, "t2");
    vectors++; if (order_code !== 12) begin miscompares++;
      $display("FAIL t2_order: got %0d want 12", order_code); end
    vectors++; if (overlap !== 0) begin miscompares++;
      $display("FAIL t2_overlap: got %0d want 0", overlap); end
    vectors++; if (beats[0] !== 8 || beats[1] !== 8) begin miscompares++;
      $display("FAIL t2_beats: got %0d/%0d want 8/8", beats[0], beats[1]); end
    vectors++; if (last_rd[1] !== DBASE + 64'd7) begin miscompares++;
      $display("FAIL t2_rdata1: got %h want %h", last_rd[1], DBASE + 64'd7); end
    vectors++; if (grant_id !== 1'b1) begin miscompares++;
      $display("FAIL t2_gid: got %b want 1", grant_id); end
  endtask

  task automatic test_rerequest();
    int n;
    logic seen;
    clear_mon();
    set_req(0, 32'h2100_0000, 16'd8);
    set_req(1, 32'h3100_0000, 16'd8);
    req_areq = 2'b11;
    n = 0;
    seen = 1'b0;
    while (n < 300) begin
      cyc();
      n++;
      if (req_busy[0]) seen = 1'b1;
      if (seen && !req_busy[0]) break;
    end
    vectors++; if (n >= 300) begin miscompares++;
      $display("FAIL t3_first: got no end of burst 0 in %0d cycles", n); end
    req_areq[0] = 1'b1;
    wait_idle(600, "t3");
    vectors++; if (order_code !== 121) begin miscompares++;
      $display("FAIL t3_order: got %0d want 121", order_code); end
    vectors++; if (overlap !== 0) begin miscompares++;
      $display("FAIL t3_overlap: got %0d want 0", overlap); end
    vectors++; if (beats[0] !== 16 || beats[1] !== 8) begin miscompares++;
      $display("FAIL t3_beats: got %0d/%0d want 16/8", beats[0], beats[1]); end
  endtask

  task automatic test_stall();
    int n, snap;
    clear_mon();
    set_req(0, 32'h4000_0000, 16'd64);
    req_areq = 2'b01;
    n = 0;
    while (beats[0] < 10 && n < 200) begin cyc(); n++; end
    vectors++; if (n >= 200) begin miscompares++;
      $display("FAIL t4_start: got %0d beats want >=10", beats[0]); end
    req_rready[0] = 1'b0;
    snap = beats[0];
    for (int k = 0; k < 5; k++) begin
      cyc();
      vectors++; if (dma_rready !== 1'b0) begin miscompares++;
        $display("FAIL t4_rready%0d: got %b want 0", k, dma_rready); end
    end
    vectors++; if (beats[0] !== snap) begin miscompares++;
      $display("FAIL t4_hold: got %0d want %0d", beats[0], snap); end
    req_rready[0] = 1'b1;
    wait_idle(400, "t4");
    vectors++; if (beats[0] !== 64) begin miscompares++;
      $display("FAIL t4_beats: got %0d want 64", beats[0]); end
  endtask

  task automatic test_zero();
    int n;
    logic seen;
    clear_mon();
    set_req(0, 32'h5000_0000, 16'd0);
    req_areq = 2'b01;
    n = 0;
    seen = 1'b0;
    do begin
      cyc();
      n++;
      if (dma_rareq) seen = 1'b1;
    end while (!(seen && req_busy == '0) && n < 60);
    vectors++; if (seen !== 1'b1) begin miscompares++;
      $display("FAIL t5_rareq: got %b want 1", seen); end
    vectors++; if (n >= 60) begin miscompares++;
      $display("FAIL t5_done: got %0d cycles want <60", n); end
    wait_idle(50, "t5");
    vectors++; if (beats[0] !== 0) begin miscompares++;
      $display("FAIL t5_beats: got %0d want 0", beats[0]); end
  endtask

`ifdef DMA_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    clear_mon();
    dma_hang = 1'b1;
    set_req(0, 32'h7000_0000, 16'd8);
    set_req(1, 32'h7100_0000, 16'd8);
    req_areq = 2'b11;
    n = 0;
    while (!dma_rareq && n < 20) begin cyc(); n++; end
    vectors++; if (n >= 20) begin miscompares++;
      $display("FAIL t6_rareq: got none in %0d cycles", n); end
    n = 0;
    while (!timeout_err && n < 300) begin cyc(); n++; end
    vectors++; if (n !== 100) begin miscompares++;
      $display("FAIL t6_wd_cycle: got %0d want 100", n); end
    cyc();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++;
      $display("FAIL t6_pulse: got %b want 0", timeout_err); end
    vectors++; if (req_busy[0] !== 1'b0) begin miscompares++;
      $display("FAIL t6_busy0: got %b want 0", req_busy[0]); end
    dma_hang = 1'b0;
    wait_idle(400, "t6");
    vectors++; if (order_code !== 12) begin miscompares++;
      $display("FAIL t6_order: got %0d want 12", order_code); end
    vectors++; if (beats[1] !== 8) begin miscompares++;
      $display("FAIL t6_beats1: got %0d want 8", beats[1]); end
    vectors++; if (terr_cnt !== 1) begin miscompares++;
      $display("FAIL t6_terr_cnt: got %0d want 1", terr_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    clear_mon();
    dma_hang = 1'b1;
    set_req(0, 32'h6000_0000, 16'd32);
    req_areq = 2'b01;
    n = 0;
    while (!(dma_rbusy && req_busy[0] && !dma_rareq) && n < 50) begin
      cyc();
      n++;
    end
    vectors++; if (n >= 50) begin miscompares++;
      $display("FAIL rm_xfer: got no XFER in %0d cycles", n); end
    repeat (HOLD) cyc();
    vectors++; if (req_busy !== 2'b01) begin miscompares++;
      $display("FAIL rm_hold: got %b want 01", req_busy); end
    vectors++; if (terr_cnt !== 0) begin miscompares++;
      $display("FAIL rm_terr: got %0d want 0", terr_cnt); end
    i_rst_n = 1'b0;
    #1;
    vectors++; if (req_busy !== 2'b00) begin miscompares++;
      $display("FAIL rm_busy: got %b want 00", req_busy); end
    vectors++; if (dma_raddr !== 32'h0 || dma_rsize !== 16'h0) begin
      miscompares++;
      $display("FAIL rm_latch: got %h/%h want 0/0", dma_raddr, dma_rsize); end
    vectors++; if (dma_rareq !== 1'b0 || grant_id !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_rareq_gid: got %b/%b want 0/0", dma_rareq, grant_id); end
    vectors++; if (dma_rready !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_rdy_terr: got %b/%b want 1/0", dma_rready, timeout_err); end
    dma_hang = 1'b0;
    cyc();
    cyc();
    i_rst_n = 1'b1;
    wait_idle(50, "rm");
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_rerequest();
    test_stall();
    test_zero();
`ifdef DMA_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
